// File: rtl/mem_pkg.sv
// Shared types for the mem_pipe memory block: response codes and the response record.
// The default-width resp_t below serves 32-bit users; mem_pipe builds its own width-matched record.
package mem_pkg;

  localparam int RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    RESP_OK       = 2'b00,
    RESP_ADDR_ERR = 2'b01,
    RESP_PAR_ERR  = 2'b10
  } resp_e;

  typedef struct packed {
    logic [31:0] rdata;
    resp_e       rresp;
  } resp_t;

  // Even parity of one byte lane: the stored bit makes the lane's total popcount even.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Synchronous response FIFO for mem_pipe; element type is a parameter so the caller
// can match its data width. Storage is not reset, only the pointers are.
module mem_resp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = mem_pkg::resp_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  T     i_din,
  input  logic i_pop,
  output T     o_dout,
  output logic o_empty,
  output logic o_full
);

  localparam int AW = $clog2(DEPTH);

  T           r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_din;
  end

  assign o_dout  = r_mem[r_rp[AW-1:0]];
  assign o_empty = (r_wp == r_rp);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);

endmodule

// File: rtl/mem_pipe.sv
// Single-port memory with valid/ready requests, byte strobes, RD_LAT-cycle in-order responses.
// Optional MEM_PARITY_EN adds per-lane even parity, a par_inj port and RESP_PAR_ERR reporting.
module mem_pipe
  import mem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LAT     = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wstrb,
`ifdef MEM_PARITY_EN
  input  logic                  par_inj,
`endif
  output logic                  rvalid,
  input  logic                  rready,
  output logic [WIDTH-1:0]      rdata,
  output logic [RESP_W-1:0]     rresp
);

  localparam int NB    = WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RESP_DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] rdata;
    resp_e            rresp;
  } rsp_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
`ifdef MEM_PARITY_EN
  logic [NB-1:0]    r_par [DEPTH];
`endif
  logic [CNT_W-1:0] r_pend;

  logic             w_acc, w_pop, w_addr_err, w_push, w_empty, w_full;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_rd_word;
  rsp_t             w_resp, w_push_d, w_head;

  assign w_acc      = valid && ready;
  assign w_pop      = rvalid && rready;
  assign w_addr_err = (32'(addr) >= DEPTH);
  assign w_idx      = addr[IDX_W-1:0];
  assign ready      = rst && (r_pend < CNT_W'(RESP_DEPTH));

  // Array: cleared on reset, byte-lane writes committed at the accept edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
`ifdef MEM_PARITY_EN
        r_par[i] <= '0;
`endif
      end
    end else if (w_acc && wr_rd && !w_addr_err) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
`ifdef MEM_PARITY_EN
          r_par[w_idx][b] <= byte_par(wdata[8*b +: 8]) ^ par_inj;
`endif
        end
      end
    end
  end

  // Response formed from the pre-edge array contents of the accepted request.
  always_comb begin
    w_rd_word    = r_mem[w_idx];
    w_resp.rdata = '0;
    w_resp.rresp = RESP_OK;
    if (w_addr_err) begin
      w_resp.rresp = RESP_ADDR_ERR;
    end else if (!wr_rd) begin
      w_resp.rdata = w_rd_word;
`ifdef MEM_PARITY_EN
      for (int b = 0; b < NB; b++) begin
        if (byte_par(w_rd_word[8*b +: 8]) != r_par[w_idx][b]) w_resp.rresp = RESP_PAR_ERR;
      end
`endif
    end
  end

  // RD_LAT-1 register stages ahead of the FIFO; the FIFO write adds the last cycle.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign w_push   = w_acc;
      assign w_push_d = w_resp;
    end else begin : g_pipe
      localparam int STAGES = RD_LAT - 1;
      logic [STAGES-1:0] vld_pipe;
      rsp_t              r_dat_pipe [STAGES];

      always_ff @(posedge clk) begin
        if (!rst) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[0] <= w_acc;
          for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end

      always_ff @(posedge clk) begin
        r_dat_pipe[0] <= w_resp;
        for (int i = 1; i < STAGES; i++) r_dat_pipe[i] <= r_dat_pipe[i-1];
      end

      assign w_push   = vld_pipe[STAGES-1];
      assign w_push_d = r_dat_pipe[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) r_pend <= '0;
    else      r_pend <= r_pend + CNT_W'(w_acc) - CNT_W'(w_pop);
  end

  mem_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (rsp_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push && !w_full),
    .i_din   (w_push_d),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Outputs forced to zero when idle so unwritten FIFO storage never leaks out.
  assign rvalid = !w_empty;
  assign rdata  = rvalid ? w_head.rdata : '0;
  assign rresp  = rvalid ? w_head.rresp : RESP_OK;

endmodule

// File: tb/tb_mem_pipe.sv
// Directed self-checking bench for mem_pipe (ADDR_WIDTH=9 so out-of-range addresses are reachable).
// Build with MEM_PARITY_EN defined to also exercise the parity path.
module tb_mem_pipe;

  localparam int W  = 32;
  localparam int D  = 256;
  localparam int AW = 9;
  localparam int RL = 2;
  localparam int RD = 4;

  logic          clk = 0;
  logic          rst = 0;
  logic          valid = 0;
  logic          ready;
  logic          wr_rd = 0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  wdata = '0;
  logic [W/8-1:0] wstrb = '0;
`ifdef MEM_PARITY_EN
  logic          par_inj = 0;
`endif
  logic          rvalid;
  logic          rready = 0;
  logic [W-1:0]  rdata;
  logic [1:0]    rresp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_pipe #(
    .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .RD_LAT(RL), .RESP_DEPTH(RD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid),
    .ready  (ready),
    .wr_rd  (wr_rd),
    .addr   (addr),
    .wdata  (wdata),
    .wstrb  (wstrb),
`ifdef MEM_PARITY_EN
    .par_inj(par_inj),
`endif
    .rvalid (rvalid),
    .rready (rready),
    .rdata  (rdata),
    .rresp  (rresp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request, wait (bounded) for ready, let it be accepted on the next edge.
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic [W/8-1:0] s);
    int n;
    n = 0;
    valid = 1; wr_rd = wr; addr = a; wdata = d; wstrb = s;
    while (!ready && n < 20) begin tick(); n++; end
    check("send_ready", ready, 1);
    tick();
    valid = 0;
  endtask

  // Wait (bounded) for a response, check it, consume it.
  task automatic expect_resp(input string tag, input logic [W-1:0] d, input logic [1:0] r);
    int n;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    check({tag, "_rvalid"}, rvalid, 1);
    check({tag, "_rdata"}, rdata, d);
    check({tag, "_rresp"}, rresp, r);
    rready = 1;
    tick();
    rready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, got, stale;
    logic cur_acc, cur_pop;

    // Reset held with a pending request
    rst = 0; valid = 1; wr_rd = 0; addr = '0; rready = 1;
    tick(); tick();
    check("rst_ready", ready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    rst = 1; valid = 0;
    tick();
    check("rel_ready", ready, 1);

    // Read addr 0 and measure latency
    valid = 1; wr_rd = 0; addr = 9'd0;
    tick();
    valid = 0;
    check("lat_cyc1_rvalid", rvalid, 0);
    tick();
    check("lat_cyc2_rvalid", rvalid, 1);
    check("rd0_rdata", rdata, 0);
    check("rd0_rresp", rresp, 0);
    tick();
    check("rd0_consumed", rvalid, 0);
    rready = 0;

    // Byte strobes, three in-order responses with hold under backpressure
    send(1, 9'd5, 32'hDEADBEEF, 4'b1111);
    send(1, 9'd5, 32'h0000AA00, 4'b0010);
    send(0, 9'd5, 32'h0, 4'b0000);
    tick();
    check("hold_rvalid", rvalid, 1);
    check("hold_rdata", rdata, 0);
    expect_resp("bs_wr1", 32'h0, 2'b00);
    expect_resp("bs_wr2", 32'h0, 2'b00);
    expect_resp("bs_rd", 32'hDEADAAEF, 2'b00);
    rready = 1;
    valid = 1; wr_rd = 0; addr = 9'd5;
    tick();
    valid = 0;
    check("bs_lat1_rvalid", rvalid, 0);
    tick();
    check("bs_lat2_rvalid", rvalid, 1);
    check("bs_lat_rdata", rdata, 32'hDEADAAEF);
    tick();
    rready = 0;

    // Backpressure: fill addrs 10..15, then six reads with rready low
    for (int i = 0; i < 6; i++) begin
      send(1, AW'(10 + i), 32'h100 + 32'(i), 4'b1111);
      expect_resp("bp_wr", 32'h0, 2'b00);
    end
    acc = 0;
    valid = 1; wr_rd = 0; addr = 9'd10;
    for (int c = 0; c < 8; c++) begin
      cur_acc = valid && ready;
      tick();
      if (cur_acc) begin
        acc++;
        addr = AW'(10 + acc);
      end
    end
    check("bp_accepts", acc, 4);
    check("bp_ready_low", ready, 0);
    rready = 1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      cur_acc = valid && ready;
      cur_pop = rvalid;
      if (cur_pop) check("bp_order", rdata, 32'h100 + 32'(got));
      tick();
      if (cur_pop) got++;
      if (cur_acc) begin
        acc++;
        addr = AW'(10 + acc);
        if (acc == 6) valid = 0;
      end
    end
    valid = 0;
    check("bp_total_acc", acc, 6);
    check("bp_total_resp", got, 6);
    rready = 0;

    // Out-of-range address
    send(1, 9'd300, 32'h12345678, 4'b1111);
    expect_resp("ae_wr", 32'h0, 2'b01);
    send(0, 9'd300, 32'h0, 4'b0000);
    expect_resp("ae_rd", 32'h0, 2'b01);
    send(0, 9'd44, 32'h0, 4'b0000);
    expect_resp("ae_alias", 32'h0, 2'b00);

    // Reset with three reads in flight
    send(0, 9'd5, 32'h0, 4'b0000);
    send(0, 9'd5, 32'h0, 4'b0000);
    send(0, 9'd5, 32'h0, 4'b0000);
    rst = 0;
    tick();
    check("mrst_rvalid", rvalid, 0);
    check("mrst_ready", ready, 0);
    rst = 1;
    #1;
    check("mrst_rel_ready", ready, 1);
    rready = 1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (rvalid) stale++;
      tick();
    end
    check("mrst_no_stale", stale, 0);
    rready = 0;
    send(0, 9'd5, 32'h0, 4'b0000);
    expect_resp("mrst_cleared", 32'h0, 2'b00);

`ifdef MEM_PARITY_EN
    par_inj = 1;
    send(1, 9'd7, 32'hA5A5A5A5, 4'b1111);
    par_inj = 0;
    expect_resp("par_wr", 32'h0, 2'b00);
    send(0, 9'd7, 32'h0, 4'b0000);
    expect_resp("par_bad", 32'hA5A5A5A5, 2'b10);
    send(1, 9'd7, 32'hA5A5A5A5, 4'b1111);
    expect_resp("par_wr2", 32'h0, 2'b00);
    send(0, 9'd7, 32'h0, 4'b0000);
    expect_resp("par_good", 32'hA5A5A5A5, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
